// File: rtl/gray_stream_gen_if.sv
// gray_stream_gen_if
//   Control and output-slot bundle for the Gray-code stream source.
//   master modport : the generator (consumes controls, drives the slot)
//   slave  modport : the environment/downstream converter
//
//   en        permits emission of the next code
//   up        direction sampled at emission (1 = increment, 0 = decrement)
//   load      synchronous load strobe for the next code
//   load_bin  binary value emitted next after a load
//   out_ready downstream accepts the slot this cycle
//   out_valid slot holds an un-accepted code
//   gray_out  Gray code in the slot
//   bin_out   binary value of the slot
//   wrap      slot code is the last before wrap-around in its direction
interface gray_stream_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             wrap;

  modport master (
    input  en,
    input  up,
    input  load,
    input  load_bin,
    input  out_ready,
    output out_valid,
    output gray_out,
    output bin_out,
    output wrap
  );

  modport slave (
    output en,
    output up,
    output load,
    output load_bin,
    output out_ready,
    input  out_valid,
    input  gray_out,
    input  bin_out,
    input  wrap
  );
endinterface

// File: rtl/gray_stream_gen.sv
// gray_stream_gen
//   Sequential Gray-code source feeding the binary/Gray converter stage.
//   An internal binary counter (nxt) supplies the next code; each emission
//   registers the code in Gray and binary form into a single valid/ready
//   output slot together with a wrap flag.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gray_stream_gen_if master: en, up, load, load_bin, out_ready in;
//          out_valid, gray_out, bin_out, wrap out
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | no pending code, out_valid = 0
//   FULL  | slot holds an un-accepted code, slot regs frozen
//
//   WIDTH legal range is 2 to 16.
module gray_stream_gen #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_stream_gen_if.master  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] nxt_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic             full;
  logic             xfer;
  logic             free;
  logic             emit;
  logic             wrap_d;
  logic [WIDTH-1:0] nxt_step;

  assign full = (state_q == FULL);
  assign xfer = full & bus.out_ready;
  assign free = !full | bus.out_ready;
  // load owns the cycle: it rewrites nxt, so nothing may be emitted from it.
  assign emit = bus.en & free & !bus.load;

  // wrap marks the final code before the counter rolls over in the
  // direction used for this emission.
  assign wrap_d   = bus.up ? (nxt_q == {WIDTH{1'b1}}) : (nxt_q == '0);
  assign nxt_step = bus.up ? (nxt_q + ONE) : (nxt_q - ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An emission refills the slot even when it is being
  // accepted in the same cycle, which gives back-to-back throughput.
  always_comb begin
    state_d = state_q;
    if (emit) begin
      state_d = FULL;
    end else if (xfer) begin
      state_d = EMPTY;
    end
  end

  // Output logic
  always_comb begin
    bus.out_valid = full;
    bus.gray_out  = gray_q;
    bus.bin_out   = bin_q;
    bus.wrap      = wrap_q;
  end

  // Counter and slot datapath. Slot registers only move on emission, so
  // they hold while stalled and keep their last contents after a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_q  <= '0;
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (bus.load) begin
        nxt_q <= bus.load_bin;
      end else if (emit) begin
        nxt_q <= nxt_step;
      end
      if (emit) begin
        bin_q  <= nxt_q;
        gray_q <= nxt_q ^ (nxt_q >> 1);
        wrap_q <= wrap_d;
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_gen.sv
module tb_gray_stream_gen;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gray_stream_gen_if #(.WIDTH(W)) bus ();

  gray_stream_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] b;
    logic       w;
  } exp_t;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lb;
    logic       rdy;
    logic       ev;
    logic [3:0] eg;
    logic [3:0] eb;
    logic       ew;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_nxt;
  logic       m_valid;
  logic [3:0] seq1 [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic i_en, input logic i_up, input logic i_load,
                     input logic [3:0] i_lb, input logic i_rdy, input logic e_v,
                     input logic [3:0] e_g, input logic [3:0] e_b, input logic e_w);
    vec_t v;
    v.en = i_en; v.up = i_up; v.load = i_load; v.lb = i_lb; v.rdy = i_rdy;
    v.ev = e_v; v.eg = e_g; v.eb = e_b; v.ew = e_w;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_nxt   = 4'd0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus. Inputs change at the falling edge; the scoreboard
  // pops on every accept seen there, and pushes what the reference model says
  // the next rising edge will emit.
  task automatic cycle(input logic i_en, input logic i_up, input logic i_load,
                       input logic [3:0] i_lb, input logic i_rdy);
    exp_t       e;
    logic       stall;
    logic [3:0] g0, b0;
    logic       w0;
    logic       accept;
    @(negedge clk);
    bus.en = i_en; bus.up = i_up; bus.load = i_load;
    bus.load_bin = i_lb; bus.out_ready = i_rdy;
    chk("valid_vs_model", 16'(bus.out_valid), 16'(m_valid));
    accept = m_valid & i_rdy;
    if (accept) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_gray", 16'(bus.gray_out), 16'(e.g));
        chk("sb_bin",  16'(bus.bin_out),  16'(e.b));
        chk("sb_wrap", 16'(bus.wrap),     16'(e.w));
        chk("gray_of_bin", 16'(bus.gray_out), 16'(bus.bin_out ^ (bus.bin_out >> 1)));
      end
    end
    stall = m_valid & !i_rdy;
    g0 = bus.gray_out; b0 = bus.bin_out; w0 = bus.wrap;
    if (i_en && (!m_valid || i_rdy) && !i_load) begin
      e.g = m_nxt ^ {1'b0, m_nxt[3:1]};
      e.b = m_nxt;
      e.w = i_up ? (m_nxt == 4'hF) : (m_nxt == 4'h0);
      sb.push_back(e);
      m_nxt   = i_up ? 4'(m_nxt + 4'd1) : 4'(m_nxt - 4'd1);
      m_valid = 1'b1;
    end else if (accept) begin
      m_valid = 1'b0;
    end
    if (i_load) m_nxt = i_lb;
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", 16'(bus.out_valid), 16'd1);
      chk("stall_gray",  16'(bus.gray_out),  16'(g0));
      chk("stall_bin",   16'(bus.bin_out),   16'(b0));
      chk("stall_wrap",  16'(bus.wrap),      16'(w0));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd0);
    chk({tag, "_gray"},  16'(bus.gray_out),  16'd0);
    chk({tag, "_bin"},   16'(bus.bin_out),   16'd0);
    chk({tag, "_wrap"},  16'(bus.wrap),      16'd0);
  endtask

  initial begin
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0;
    bus.load_bin = 4'd0; bus.out_ready = 1'b0;
    model_reset();

    seq1 = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // up count, no backpressure
    for (int k = 0; k < 17; k++)
      add(1, 1, 0, 4'h0, 1, 1, seq1[k], 4'(k), (k == 15));
    // backpressure at gray 0011 / bin 0010
    add(1, 1, 0, 4'h0, 1, 1, 4'h1, 4'h1, 0);
    add(1, 1, 0, 4'h0, 1, 1, 4'h3, 4'h2, 0);
    for (int k = 0; k < 3; k++)
      add(1, 1, 0, 4'h0, 0, 1, 4'h3, 4'h2, 0);
    add(1, 1, 0, 4'h0, 1, 1, 4'h2, 4'h3, 0);
    // drain, load 0101 while empty (load beats en), count down across zero
    add(0, 1, 0, 4'h0, 1, 0, 4'h2, 4'h3, 0);
    add(1, 1, 1, 4'h5, 1, 0, 4'h2, 4'h3, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h7, 4'h5, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h6, 4'h4, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h2, 4'h3, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h3, 4'h2, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h1, 4'h1, 0);
    add(1, 0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1);
    add(1, 0, 0, 4'h0, 1, 1, 4'h8, 4'hF, 0);
    // load 1010 while holding gray 0110 stalled
    add(0, 1, 0, 4'h0, 1, 0, 4'h8, 4'hF, 0);
    add(0, 1, 1, 4'h4, 1, 0, 4'h8, 4'hF, 0);
    add(1, 1, 0, 4'h0, 0, 1, 4'h6, 4'h4, 0);
    add(1, 1, 1, 4'hA, 0, 1, 4'h6, 4'h4, 0);
    add(1, 1, 0, 4'h0, 0, 1, 4'h6, 4'h4, 0);
    add(1, 1, 0, 4'h0, 1, 1, 4'hF, 4'hA, 0);
    // en gating: accept without emission, then resume with no duplicate
    add(0, 1, 0, 4'h0, 1, 0, 4'hF, 4'hA, 0);
    add(0, 1, 0, 4'h0, 1, 0, 4'hF, 4'hA, 0);
    add(1, 1, 0, 4'h0, 1, 1, 4'hE, 4'hB, 0);

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lb, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), 16'(bus.out_valid), 16'(tbl[i].ev));
      chk($sformatf("t%0d_gray", i),  16'(bus.gray_out),  16'(tbl[i].eg));
      chk($sformatf("t%0d_bin", i),   16'(bus.bin_out),   16'(tbl[i].eb));
      chk($sformatf("t%0d_wrap", i),  16'(bus.wrap),      16'(tbl[i].ew));
    end

    // asynchronous reset between edges while FULL
    chk("pre_reset_full", 16'(bus.out_valid), 16'd1);
    #2;
    bus.en = 1'b0; bus.load = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 0, 4'h0, 1);
    chk("post_rst_valid", 16'(bus.out_valid), 16'd1);
    chk("post_rst_gray",  16'(bus.gray_out),  16'd0);
    chk("post_rst_bin",   16'(bus.bin_out),   16'd0);
    cycle(1, 1, 0, 4'h0, 1);
    chk("post_rst_gray2", 16'(bus.gray_out),  16'd1);

    // random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end

    cycle(0, 1, 0, 4'h0, 1);
    cycle(0, 1, 0, 4'h0, 1);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    chk("final_valid", 16'(bus.out_valid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_stream_gen.md
Name: gray_stream_gen

Overview:
- Sequential Gray-code source that sits directly upstream of the team's binary/Gray converter stage.
- Keeps an internal binary counter and presents each count as a registered Gray code, together with its binary value, on a valid/ready output slot.
- Supports up/down counting, synchronous load of a binary start value, and a wrap flag.
- The downstream converter, run in Gray-to-binary direction, must reproduce bin_out for every accepted code; this is the system-level check.

Parameters:
- WIDTH, 4, code width in bits; legal range 2 to 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  permits emission of the next code
- up  input  1  direction, sampled at emission: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_bin  input  WIDTH  binary value loaded as the next code to emit
- out_ready  input  1  downstream accepts the slot this cycle
- out_valid  output  1  slot holds an un-accepted code
- gray_out  output  WIDTH  Gray code in the slot, equal to bin_out ^ (bin_out >> 1)
- bin_out  output  WIDTH  binary value of the slot
- wrap  output  1  slot code is the last one before wrap-around in the direction used at its emission

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 immediately forces all state, independent of clk.
- Reset values:
  - internal next-count nxt = 0
  - gray_out = 0, bin_out = 0
  - out_valid = 0, wrap = 0
  - FSM state = EMPTY
- Reset asserted mid-operation discards any pending code. The first emission after release is binary 0.
- FSM states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1; slot registers are held stable.
- Definitions:
  - xfer = out_valid & out_ready.
  - free = !out_valid | out_ready.
- Emission (en & free & !load), at the clock edge:
  - bin_out <= nxt, gray_out <= nxt ^ (nxt >> 1).
  - wrap <= (up & nxt == all-ones) | (!up & nxt == 0).
  - nxt <= nxt + 1 if up, else nxt - 1, modulo 2^WIDTH.
  - State -> FULL.
- Transfer without emission (xfer & (!en | load)): state -> EMPTY, out_valid -> 0. Slot data and wrap hold their last values.
- Stall (FULL & !out_ready):
  - Slot, out_valid and nxt are unchanged regardless of en and up.
  - gray_out and bin_out must not change while out_valid=1 and out_ready=0.
- Load (highest priority):
  - nxt <= load_bin. No emission occurs in that cycle.
  - The slot is unaffected: a pending code stays valid. An xfer in the same cycle still empties the slot.
  - The loaded value is the next code emitted.
- Latency and throughput:
  - A code appears one cycle after an emission cycle.
  - Sustained en=1 with out_ready=1 gives one code per cycle (back-to-back, no bubbles).
- Sequence property: consecutive emitted Gray codes differ in exactly one bit. Exceptions are across a load or a direction change.
- wrap is meaningful only while out_valid=1. It is a sideband of the slot, not a pulse.

Test Plan:
1. Up count, no backpressure: reset, then en=1, up=1, out_ready=1.
   - Required: out_valid rises one cycle after the first en cycle.
   - gray_out sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000.
   - wrap=1 only on 1000 (bin 1111); the next code is 0000 with wrap=0.
2. Backpressure: at slot gray 0011 (bin 0010), hold out_ready=0 for 3 cycles with en=1.
   - Required: slot holds 0011/0010 and out_valid stays 1 for all 3 cycles.
   - After out_ready=1, the next code is 0010 (bin 0011), with no skipped or duplicated codes.
3. Load and count down: load=1, load_bin=0101 while EMPTY, then en=1, up=0, out_ready=1.
   - Required: gray_out 0111, 0110, 0010, 0011, 0001, 0000 (wrap=1 on 0000), then 1000 (bin 1111).
4. Load while FULL and stalled: slot holds 0110, out_ready=0, load=1, load_bin=1010.
   - Required: the slot keeps 0110 until accepted.
   - The next emitted code is gray 1111 (bin 1010).
5. Reset mid-stream: assert rst_n=0 asynchronously between clock edges while FULL.
   - Required: out_valid, gray_out, bin_out and wrap go to 0 immediately.
   - After release with en=1, the first code is 0000.
6. en gating: en=0, out_ready=1 while FULL.
   - Required: the slot is accepted and out_valid drops to 0.
   - nxt is unchanged; the next en=1 emits the following code with no duplicate.
